// File: rtl/ssd1306_seq_pkg.sv
// Shared constants for the SSD1306 script sequencer: local opcodes, ROM entry
// field positions and the FSM state encoding.
package ssd1306_seq_pkg;

  localparam logic [3:0] OP_SET_RESET = 4'h1;
  localparam logic [3:0] OP_SET_VBAT  = 4'h2;
  localparam logic [3:0] OP_DELAY     = 4'h3;
  localparam logic [3:0] OP_SET_VCD   = 4'h4;
  localparam logic [3:0] OP_SET_DC    = 4'h5;
  localparam logic [3:0] OP_REPEAT    = 4'h6;
  localparam logic [3:0] OP_STOP      = 4'hF;

  localparam int ROM_LOCAL_BIT = 9;
  localparam int ROM_LAST_BIT  = 8;
  localparam int WD_WIDTH      = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_FETCH,
    S_DELAY,
    S_SEND,
    S_WAIT,
    S_RETIRE,
    S_REP_LOAD,
    S_DONE
  } state_t;

endpackage

// File: rtl/ssd1306_seq_delay.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Used for the DELAY opcode and the optional transfer watchdog.
module ssd1306_seq_delay
  import ssd1306_seq_pkg::*;
#(
  parameter int WIDTH = WD_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ssd1306_seq.sv
// Restartable SSD1306 command sequencer walking an external script ROM.
// Optional macro SSD1306_SEQ_TIMEOUT_EN adds a 16-bit transfer watchdog.
module ssd1306_seq
  import ssd1306_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int DELAY_SHIFT = 13,
  parameter bit AUTOSTART   = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  resetn_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] start_addr_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [ADDR_WIDTH-1:0] rom_addr_out,
  input  logic [9:0]            rom_data_in,
  output logic                  command_start,
  output logic [7:0]            command_out,
  output logic                  command_last_byte,
  input  logic                  command_ready,
  output logic                  oled_rstn,
  output logic                  oled_vbatn,
  output logic                  oled_vcdn,
  output logic                  oled_dc,
  output state_t                dbg_state_out
);

  localparam int DLY_WIDTH = 4 + DELAY_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  // Handshake: command_start is held high for the whole SEND state; the shift
  // register takes the byte and drops command_ready, which ends SEND. The next
  // byte is only offered once command_ready has returned high in WAIT.

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t     state;
  logic       auto_pend;
  logic       rep_active;
  logic       rep_phase;
  logic [7:0] rep_cnt;

  logic       rom_local;
  logic       rom_last;
  logic [3:0] rom_op;
  logic [3:0] rom_arg;

  assign rom_local = rom_data_in[ROM_LOCAL_BIT];
  assign rom_last  = rom_data_in[ROM_LAST_BIT];
  assign rom_op    = rom_data_in[7:4];
  assign rom_arg   = rom_data_in[3:0];

  logic                 dly_load;
  logic                 dly_expired;
  logic [DLY_WIDTH-1:0] dly_val;

  assign dly_load = (state == S_FETCH) && rom_local && (rom_op == OP_DELAY);
  assign dly_val  = DLY_WIDTH'(rom_arg) << DELAY_SHIFT;

  ssd1306_seq_delay #(.WIDTH(DLY_WIDTH)) u_delay (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (dly_val),
    .en       (state == S_DELAY),
    .expired  (dly_expired)
  );

  logic waiting;
  logic timeout;
  assign waiting = (state == S_WAIT_RDY) || (state == S_SEND) || (state == S_WAIT);

`ifdef SSD1306_SEQ_TIMEOUT_EN
  state_t wd_prev;
  logic   wd_load;
  logic   wd_expired;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) wd_prev <= S_IDLE;
    else        wd_prev <= state;
  end

  // Reloaded on the first cycle of every state, so only a single stalled
  // state can run the count down.
  assign wd_load = (state != wd_prev);

  ssd1306_seq_delay #(.WIDTH(WD_WIDTH)) u_watchdog (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (wd_load),
    .load_val ({WD_WIDTH{1'b1}}),
    .en       (waiting),
    .expired  (wd_expired)
  );

  assign timeout = waiting && wd_expired && !wd_load;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      auto_pend         <= AUTOSTART;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      error_out         <= 1'b0;
      rom_addr_out      <= '0;
      command_start     <= 1'b0;
      command_out       <= 8'h00;
      command_last_byte <= 1'b0;
      oled_rstn         <= 1'b0;
      oled_vbatn        <= 1'b1;
      oled_vcdn         <= 1'b1;
      oled_dc           <= 1'b0;
      rep_active        <= 1'b0;
      rep_phase         <= 1'b0;
      rep_cnt           <= 8'h00;
    end else begin
      done_out  <= 1'b0;
      auto_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in || auto_pend) begin
            rom_addr_out <= auto_pend ? '0 : start_addr_in;
            error_out    <= 1'b0;
            busy_out     <= 1'b1;
            state        <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (timeout) begin
            error_out <= 1'b1;
            state     <= S_DONE;
          end else if (command_ready) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!rom_local) begin
            command_out       <= rom_data_in[7:0];
            command_last_byte <= rom_last;
            command_start     <= 1'b1;
            rep_active        <= 1'b0;
            state             <= S_SEND;
          end else begin
            case (rom_op)
              OP_SET_RESET: begin oled_rstn  <= rom_arg[0]; state <= S_RETIRE; end
              OP_SET_VBAT:  begin oled_vbatn <= rom_arg[0]; state <= S_RETIRE; end
              OP_SET_VCD:   begin oled_vcdn  <= rom_arg[0]; state <= S_RETIRE; end
              OP_SET_DC:    begin oled_dc    <= rom_arg[0]; state <= S_RETIRE; end
              OP_DELAY:     state <= S_DELAY;
              OP_REPEAT: begin
                if (rom_addr_out == ADDR_MAX) begin
                  error_out <= 1'b1;
                  state     <= S_DONE;
                end else begin
                  rom_addr_out <= rom_addr_out + 1'b1;
                  rep_phase    <= 1'b0;
                  state        <= S_REP_LOAD;
                end
              end
              OP_STOP: state <= S_DONE;
              default: begin
                error_out <= 1'b1;
                state     <= S_DONE;
              end
            endcase
          end
        end
        S_DELAY: begin
          if (dly_expired) state <= S_RETIRE;
        end
        // Phase 0 latches the count byte, phase 1 latches the data byte.
        S_REP_LOAD: begin
          if (!rep_phase) begin
            if (rom_addr_out == ADDR_MAX) begin
              error_out <= 1'b1;
              state     <= S_DONE;
            end else begin
              rep_cnt      <= rom_data_in[7:0];
              rom_addr_out <= rom_addr_out + 1'b1;
              rep_phase    <= 1'b1;
            end
          end else begin
            command_out       <= rom_data_in[7:0];
            command_last_byte <= rom_last && (rep_cnt == 8'd0);
            command_start     <= 1'b1;
            rep_active        <= 1'b1;
            state             <= S_SEND;
          end
        end
        S_SEND: begin
          if (timeout) begin
            command_start <= 1'b0;
            error_out     <= 1'b1;
            state         <= S_DONE;
          end else if (!command_ready) begin
            command_start <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (timeout) begin
            error_out <= 1'b1;
            state     <= S_DONE;
          end else if (command_ready) begin
            if (rep_active && (rep_cnt != 8'd0)) begin
              rep_cnt           <= rep_cnt - 1'b1;
              command_last_byte <= rom_last && (rep_cnt == 8'd1);
              command_start     <= 1'b1;
              state             <= S_SEND;
            end else begin
              rep_active <= 1'b0;
              state      <= S_RETIRE;
            end
          end
        end
        S_RETIRE: begin
          if (rom_addr_out == ADDR_MAX) begin
            error_out <= 1'b1;
            state     <= S_DONE;
          end else begin
            rom_addr_out <= rom_addr_out + 1'b1;
            state        <= S_FETCH;
          end
        end
        S_DONE: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_out = state;

endmodule

// File: tb/tb_ssd1306_seq.sv
// Scoreboard bench for ssd1306_seq: a script-walking reference model fills an
// expected queue; a monitor pops it on every accepted byte and every done pulse.
module tb_ssd1306_seq;
  import ssd1306_seq_pkg::*;

  localparam int AW    = 6;
  localparam int DS    = 2;
  localparam int DEPTH = 64;
  localparam int W     = 15;

  logic          clk_in        = 1'b0;
  logic          resetn_in     = 1'b0;
  logic          start_in      = 1'b0;
  logic [AW-1:0] start_addr_in = '0;
  logic          command_ready = 1'b1;
  logic          busy_out, done_out, error_out;
  logic [AW-1:0] rom_addr_out;
  logic [9:0]    rom_data_in;
  logic          command_start, command_last_byte;
  logic [7:0]    command_out;
  logic          oled_rstn, oled_vbatn, oled_vcdn, oled_dc;
  state_t        dbg_state_out;

  logic [9:0] rom [DEPTH];
  assign rom_data_in = rom[rom_addr_out];

  ssd1306_seq #(.ADDR_WIDTH(AW), .DELAY_SHIFT(DS), .AUTOSTART(1'b1)) dut (
    .clk_in            (clk_in),
    .resetn_in         (resetn_in),
    .start_in          (start_in),
    .start_addr_in     (start_addr_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .error_out         (error_out),
    .rom_addr_out      (rom_addr_out),
    .rom_data_in       (rom_data_in),
    .command_start     (command_start),
    .command_out       (command_out),
    .command_last_byte (command_last_byte),
    .command_ready     (command_ready),
    .oled_rstn         (oled_rstn),
    .oled_vbatn        (oled_vbatn),
    .oled_vcdn         (oled_vcdn),
    .oled_dc           (oled_dc),
    .dbg_state_out     (dbg_state_out)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- counters, scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  bit m_rstn = 1'b0, m_vbatn = 1'b1, m_vcdn = 1'b1, m_dc = 1'b0;

  function automatic void model_reset();
    m_rstn = 1'b0; m_vbatn = 1'b1; m_vcdn = 1'b1; m_dc = 1'b0;
  endfunction

  function automatic void push_send(input logic [7:0] b, input logic last);
    exp_q.push_back({4'b0000, 1'b0, 1'b0, last, b});
  endfunction

  function automatic void push_done(input logic err);
    exp_q.push_back({m_rstn, m_vbatn, m_vcdn, m_dc, 1'b1, err, 1'b0, 8'h00});
  endfunction

  // Walks the script as written in ROM and records what the panel should see.
  function automatic void model_run(input int start);
    int         a;
    bit         fin;
    bit         err;
    logic [9:0] e;
    logic [9:0] d;
    logic [7:0] c;
    a = start; fin = 1'b0; err = 1'b0;
    while (!fin) begin
      e = rom[a];
      if (!e[9]) begin
        push_send(e[7:0], e[8]);
      end else begin
        case (e[7:4])
          4'h1: m_rstn  = e[0];
          4'h2: m_vbatn = e[0];
          4'h4: m_vcdn  = e[0];
          4'h5: m_dc    = e[0];
          4'h3: ;
          4'h6: begin
            if (a + 2 > DEPTH - 1) begin
              err = 1'b1; fin = 1'b1;
            end else begin
              e = rom[a + 1];
              c = e[7:0];
              d = rom[a + 2];
              for (int i = 0; i <= int'(c); i++) push_send(d[7:0], d[8] && (i == int'(c)));
              a += 2;
            end
          end
          4'hF: fin = 1'b1;
          default: begin err = 1'b1; fin = 1'b1; end
        endcase
      end
      if (!fin) begin
        if (a == DEPTH - 1) begin err = 1'b1; fin = 1'b1; end
        else a++;
      end
    end
    push_done(err);
  endfunction

  // ---------------- shift-register model (drives command_ready) ----------------
  bit stuck      = 1'b0;
  bit fast_ready = 1'b0;

  always begin
    @(posedge clk_in); #2;
    if (!resetn_in) begin
      command_ready = 1'b1;
    end else if (command_start && command_ready) begin
      command_ready = 1'b0;
      if (!stuck) begin
        repeat (fast_ready ? 1 : $urandom_range(1, 3)) @(posedge clk_in);
        #2;
        command_ready = 1'b1;
      end
    end else if (!command_ready && !stuck) begin
      command_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  int            sends_seen   = 0;
  int            done_seen    = 0;
  int            delay_cycles = 0;
  bit            wrap_seen    = 1'b0;
  logic [AW-1:0] prev_addr    = '0;

  always begin
    logic [W-1:0] e;
    @(posedge clk_in); #1;
    if (resetn_in) begin
      if (dbg_state_out == S_DELAY) delay_cycles++;
      if (busy_out && dbg_state_out != S_WAIT_RDY && prev_addr == AW'(DEPTH - 1) && rom_addr_out == '0)
        wrap_seen = 1'b1;
      prev_addr = rom_addr_out;
      if (command_start && command_ready) begin
        sends_seen++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL send_unexpected: actual=%0h expected=none", command_out);
        end else begin
          e = exp_q.pop_front();
          check("send_item", {4'b0000, 1'b0, 1'b0, command_last_byte, command_out}, e);
        end
      end
      if (done_out) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: actual=err%0d expected=none", error_out);
        end else begin
          e = exp_q.pop_front();
          check("done_item", {oled_rstn, oled_vbatn, oled_vcdn, oled_dc, 1'b1, error_out, 1'b0, 8'h00}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int addr);
    @(negedge clk_in);
    start_in = 1'b1; start_addr_in = AW'(addr);
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_seen == base && n < budget) begin
      @(posedge clk_in); #3;
      n++;
    end
    check(name, done_seen != base, 1);
  endtask

  task automatic gen_script();
    int         p;
    logic [3:0] op;
    p = 36;
    while (p < 46) begin
      case ($urandom_range(0, 7))
        1, 7: begin
          case ($urandom_range(0, 3))
            0: op = 4'h1;
            1: op = 4'h2;
            2: op = 4'h4;
            default: op = 4'h5;
          endcase
          rom[p] = {2'b10, op, 4'($urandom)}; p++;
        end
        2: begin rom[p] = {2'b10, 4'h3, 4'($urandom)}; p++; end
        3: begin
          if (p + 3 <= 46) begin
            rom[p]     = 10'h260;
            rom[p + 1] = {2'b00, 8'($urandom_range(0, 5))};
            rom[p + 2] = {1'b0, 1'($urandom), 8'($urandom)};
            p += 3;
          end
        end
        4: begin rom[p] = {2'b10, 4'($urandom_range(7, 14)), 4'($urandom)}; p++; end
        default: begin rom[p] = {1'b0, 1'($urandom), 8'($urandom)}; p++; end
      endcase
    end
    rom[p] = 10'h2F0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int s0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 10'h2F0;
    rom[0]  = 10'h211; rom[1]  = 10'h231; rom[2]  = 10'h1AF; rom[3]  = 10'h2F0;
    rom[16] = 10'h251; rom[17] = 10'h260; rom[18] = 10'h003; rom[19] = 10'h100; rom[20] = 10'h2F0;
    rom[32] = 10'h260; rom[33] = 10'h005; rom[34] = 10'h155; rom[35] = 10'h2F0;
    rom[48] = 10'h270;
    for (int i = 56; i < DEPTH; i++) rom[i] = (i % 2 == 0) ? 10'h251 : 10'h250;

    // reset values
    #12;
    check("rst_rstn", oled_rstn, 0);
    check("rst_vbatn", oled_vbatn, 1);
    check("rst_vcdn", oled_vcdn, 1);
    check("rst_dc", oled_dc, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_error", error_out, 0);
    check("rst_addr", rom_addr_out, 0);
    check("rst_cmd_start", command_start, 0);

    // autostart script at 0
    model_run(0);
    base = done_seen; delay_cycles = 0;
    @(negedge clk_in); resetn_in = 1'b1;
    wait_done(base, 300, "autostart_done");
    check("delay_cycles", delay_cycles, (1 << DS) + 1);
    check("rstn_up", oled_rstn, 1);
    check("queue_autostart", exp_q.size(), 0);

    // REPEAT with 1-cycle ready drop
    fast_ready = 1'b1;
    model_run(16);
    base = done_seen; s0 = sends_seen;
    do_start(16);
    wait_done(base, 300, "repeat_done");
    check("repeat_dc", oled_dc, 1);
    check("repeat_sends", sends_seen - s0, 4);
    check("queue_repeat", exp_q.size(), 0);
    fast_ready = 1'b0;

    // undefined opcode
    model_run(48);
    base = done_seen; s0 = sends_seen;
    do_start(48);
    wait_done(base, 100, "badop_done");
    check("badop_error", error_out, 1);
    check("badop_sends", sends_seen - s0, 0);
    check("queue_badop", exp_q.size(), 0);

    // run off the end of the ROM
    model_run(56);
    base = done_seen;
    do_start(56);
    wait_done(base, 200, "nostop_done");
    check("nostop_error", error_out, 1);
    check("nostop_wrap", wrap_seen, 0);
    check("nostop_addr", rom_addr_out, DEPTH - 1);
    check("queue_nostop", exp_q.size(), 0);

    // random scripts, with ignored start requests while busy
    for (int it = 0; it < 20; it++) begin
      gen_script();
      model_run(36);
      base = done_seen;
      do_start(36);
      repeat ($urandom_range(1, 8)) @(negedge clk_in);
      if (busy_out) begin
        start_in = 1'b1; start_addr_in = AW'($urandom);
        @(negedge clk_in);
        start_in = 1'b0;
      end
      wait_done(base, 3000, "rand_done");
      check("queue_rand", exp_q.size(), 0);
    end

    // reset during the second REPEAT byte, then clean restart
    model_run(32);
    s0 = sends_seen;
    do_start(32);
    for (int n = 0; n < 500 && sends_seen < s0 + 2; n++) begin
      @(posedge clk_in); #3;
    end
    check("midrep_reached", sends_seen >= s0 + 2, 1);
    resetn_in = 1'b0;
    #1;
    check("midrst_rstn", oled_rstn, 0);
    check("midrst_vbatn", oled_vbatn, 1);
    check("midrst_vcdn", oled_vcdn, 1);
    check("midrst_dc", oled_dc, 0);
    check("midrst_busy", busy_out, 0);
    check("midrst_error", error_out, 0);
    check("midrst_addr", rom_addr_out, 0);
    check("midrst_cmd_start", command_start, 0);
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk_in);
    model_run(0);
    base = done_seen;
    resetn_in = 1'b1;
    wait_done(base, 300, "restart_auto_done");
    model_run(32);
    base = done_seen; s0 = sends_seen;
    do_start(32);
    wait_done(base, 500, "restart_done");
    check("restart_sends", sends_seen - s0, 6);
    check("queue_restart", exp_q.size(), 0);

    // stalled shift register
    stuck = 1'b1;
    m_dc  = 1'b1;
    push_send(8'h00, 1'b0);
    base = done_seen;
`ifdef SSD1306_SEQ_TIMEOUT_EN
    push_done(1'b1);
    do_start(16);
    wait_done(base, 70000, "timeout_done");
    check("timeout_error", error_out, 1);
    check("queue_timeout", exp_q.size(), 0);
`else
    do_start(16);
    repeat (3000) @(posedge clk_in);
    #3;
    check("stall_busy", busy_out, 1);
    check("stall_no_done", done_seen - base, 0);
    check("queue_stall", exp_q.size(), 0);
`endif
    stuck = 1'b0;
    resetn_in = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ssd1306_seq.md
Name: ssd1306_seq

Overview:
Parametrised, restartable command sequencer for SSD1306 displays; next generation of the fixed power-on init engine. Walks an external script ROM from a caller-selected entry address, so init, power-down, contrast and other scripts share one engine. Adds DC control, VCC control, byte repeat (clear-screen fills), error reporting, and a 2-entry local-command format. Sits between top-level display control and the SPI shift-register (command_start/command_ready handshake).

Parameters:
ADDR_WIDTH, 6, script ROM address width; depth = 2**ADDR_WIDTH.
DELAY_SHIFT, 13, left shift applied to the 4-bit delay argument.
AUTOSTART, 1, 1 = run script at address 0 after reset release.

Ports:
clk_in  in  1  system clock
resetn_in  in  1  asynchronous active-low reset
start_in  in  1  one-cycle request to run a script; ignored while busy_out=1
start_addr_in  in  ADDR_WIDTH  script entry address, sampled with start_in
busy_out  out  1  high from accepted start until STOP
done_out  out  1  one-cycle pulse when a script ends (STOP or error)
error_out  out  1  sticky; cleared by next accepted start
rom_addr_out  out  ADDR_WIDTH  script ROM address (ROM is combinational)
rom_data_in  in  10  [9] local, [8] last_byte, [7:0] byte / {opcode[7:4], arg[3:0]}
command_start  out  1  high while in SEND
command_out  out  8  byte to shift register
command_last_byte  out  1  rom_data_in[8] passthrough
command_ready  in  1  shift register idle
oled_rstn, oled_vbatn, oled_vcdn, oled_dc  out  1  panel control lines

Behaviour:
- Reset (async assert, sync deassert used internally): oled_rstn=0, oled_vbatn=1, oled_vcdn=1, oled_dc=0, busy_out=0, done_out=0, error_out=0, rom_addr_out=0, state=IDLE; AUTOSTART=1 acts as start_in with address 0 on the first cycle after reset release.
- States: IDLE, WAIT_RDY, FETCH, DELAY, SEND, WAIT, RETIRE, REP_LOAD, DONE.
- IDLE: on start, load rom_addr_out, clear error_out, busy_out=1, go WAIT_RDY. WAIT_RDY -> FETCH when command_ready=1.
- FETCH, non-local entry: go SEND.
- FETCH, local opcodes: 1 SET_RESET (oled_rstn=arg[0]); 2 SET_VBAT (oled_vbatn=arg[0]); 4 SET_VCD (oled_vcdn=arg[0]); 5 SET_DC (oled_dc=arg[0]). Each of these goes RETIRE.
- FETCH, opcode 3 DELAY: counter = arg<<DELAY_SHIFT; stays in DELAY exactly counter+1 cycles, then RETIRE; arg=0 gives 1 cycle.
- FETCH, opcode 6 REPEAT: go REP_LOAD. Address+1 holds the count byte C; repeat count = C+1 (1..256). Address+2 holds the non-local byte, sent C+1 times. Then continue at address+3. command_last_byte applies only to the final repetition.
- FETCH, opcode F STOP: go DONE.
- FETCH, any other opcode: error_out=1, go DONE.
- SEND: leave when command_ready=0. WAIT: go RETIRE when command_ready=1.
- RETIRE: address+1 -> FETCH. If the address is at 2**ADDR_WIDTH-1, set error_out=1 and go DONE; no wrap.
- DONE: done_out=1 for one cycle, busy_out=0, go IDLE. Panel lines keep their values.
- start_in during busy: ignored, no error.
- Reset mid-script: immediate abort to reset values.

Optional Feature:
SSD1306_SEQ_TIMEOUT_EN:
- Defined: a 16-bit watchdog counts cycles spent in WAIT_RDY/SEND/WAIT and clears on each state change. On reaching 0xFFFF it sets error_out=1 and goes DONE.
- Undefined: no watchdog; the sequencer waits indefinitely.

Decomposition:
- Package ssd1306_seq_pkg: opcode localparams (OP_SET_RESET=1, OP_SET_VBAT=2, OP_DELAY=3, OP_SET_VCD=4, OP_SET_DC=5, OP_REPEAT=6, OP_STOP=4'hF), ROM field bit positions, state enum typedef.
- One sub-module: ssd1306_seq_delay (loadable down-counter with expired flag), reused for DELAY and the watchdog.

Test Plan:
- AUTOSTART, script {RESET 1, DELAY 1, byte AF last, STOP}, DELAY_SHIFT=2: oled_rstn rises; DELAY lasts exactly 5 cycles; one command_start with command_out=0xAF, last=1; done_out pulses once.
- start_in addr=0x10, script {SET_DC 1, REPEAT, 0x03, byte 0x00, STOP}, 1-cycle ready drop model: oled_dc=1; exactly 4 sends of 0x00; last_byte only on 4th.
- Undefined opcode 0x7 at start address: error_out=1, done_out pulse, no command_start.
- Script with no STOP through address 63: error_out=1 at RETIRE of 63, rom_addr_out never wraps to 0.
- resetn_in asserted mid-REPEAT (2nd byte): all outputs to reset values next edge; restart runs cleanly.
- With SSD1306_SEQ_TIMEOUT_EN, command_ready stuck 0 during SEND: error_out after 65535 cycles; without the macro, busy_out stays 1.
